// File: rtl/servo_pkg.sv
// Shared constants and elaboration-time helpers for the servo PWM controller.
package servo_pkg;

    localparam logic [7:0] DEFAULT_DUTY = 8'd128;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int calc_period_cyc(input int clock_freq, input int pwm_freq);
        return clock_freq / pwm_freq;
    endfunction

    function automatic int calc_min_cyc(input int clock_freq, input int pulse_us);
        return (clock_freq / 1_000_000) * pulse_us;
    endfunction

    // Truncated so that width(255) never exceeds the nominal maximum pulse.
    function automatic int calc_step_cyc(input int clock_freq, input int min_us, input int max_us);
        return (calc_min_cyc(clock_freq, max_us) - calc_min_cyc(clock_freq, min_us)) / 255;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: duty register, frame-synchronous shadow width and
// registered output comparator.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int CW         = 20,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_CYC    = 50_000,
    parameter int STEP_CYC   = 196
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CW-1:0] phase_i,
    input  logic          we_i,
    input  logic [7:0]    data_i,
    output logic          pwm_o
);

    localparam logic [CW-1:0] LAST_PHASE  = CW'(PERIOD_CYC - 1);
    localparam logic [CW-1:0] MIN_W       = CW'(MIN_CYC);
    localparam logic [CW-1:0] STEP_W      = CW'(STEP_CYC);
    localparam logic [CW-1:0] RESET_WIDTH = MIN_W + CW'(DEFAULT_DUTY) * STEP_W;

    logic [7:0]    duty_q, duty_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] target_w;
    logic          pwm_q, pwm_d;

    // The shadow samples duty_q, so a write on the wrap cycle lands a frame later.
    always_comb begin
        target_w = MIN_W + CW'(duty_q) * STEP_W;
        duty_d   = we_i ? data_i : duty_q;
        width_d  = (phase_i == LAST_PHASE) ? target_w : width_q;
        pwm_d    = (phase_i < width_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_q  <= DEFAULT_DUTY;
            width_q <= RESET_WIDTH;
            pwm_q   <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/n_channel_servo_ctrl.sv
// N-channel 50 Hz hobby-servo PWM generator with a shared duty write port.
// Optional SERVO_PHASE_STAGGER_EN spreads channel rising edges across the frame.
module n_channel_servo_ctrl
    import servo_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int NO_OF_CHANNEL = 4,
    parameter int PWM_FREQ      = 50,
    parameter int MIN_PULSE_US  = 1000,
    parameter int MAX_PULSE_US  = 2000,
    localparam int ADDRESS_WIDTH = (clog2(NO_OF_CHANNEL) < 1) ? 1 : clog2(NO_OF_CHANNEL)
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     LOAD_SIGNAL,
    input  logic [7:0]               DUTY_CYCLE_CONTROL,
    input  logic [ADDRESS_WIDTH-1:0] SERVO_SELECTOR,
    output logic [NO_OF_CHANNEL-1:0] PWM_SIGNALS
);

    localparam int PERIOD_CYC = calc_period_cyc(CLOCK_FREQ, PWM_FREQ);
    localparam int MIN_CYC    = calc_min_cyc(CLOCK_FREQ, MIN_PULSE_US);
    localparam int STEP_CYC   = calc_step_cyc(CLOCK_FREQ, MIN_PULSE_US, MAX_PULSE_US);
    localparam int CW         = (clog2(PERIOD_CYC) < 1) ? 1 : clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar k = 0; k < NO_OF_CHANNEL; k++) begin : g_ch
        logic [CW-1:0] phase;
        logic          we;

`ifdef SERVO_PHASE_STAGGER_EN
        localparam int OFFSET = int'((longint'(k) * longint'(PERIOD_CYC)) / NO_OF_CHANNEL);
        logic [CW:0] sum;
        assign sum   = {1'b0, cnt_q} + (CW+1)'(OFFSET);
        assign phase = (sum >= (CW+1)'(PERIOD_CYC)) ? CW'(sum - (CW+1)'(PERIOD_CYC)) : CW'(sum);
`else
        assign phase = cnt_q;
`endif

        // Selectors at or beyond NO_OF_CHANNEL match no channel and are dropped.
        assign we = LOAD_SIGNAL && (SERVO_SELECTOR == ADDRESS_WIDTH'(k));

        servo_pwm_channel #(
            .CW         (CW),
            .PERIOD_CYC (PERIOD_CYC),
            .MIN_CYC    (MIN_CYC),
            .STEP_CYC   (STEP_CYC)
        ) u_channel (
            .clk_i   (CLOCK),
            .rst_i   (RESET),
            .phase_i (phase),
            .we_i    (we),
            .data_i  (DUTY_CYCLE_CONTROL),
            .pwm_o   (PWM_SIGNALS[k])
        );
    end

endmodule

// File: tb/tb_n_channel_servo_ctrl.sv
// Directed bench for n_channel_servo_ctrl, scaled to a 5000-cycle frame
// (1 MHz clock, 200 Hz frame): widths 0:1000, 128:1384, 192:1576, 255:1765.
module tb_n_channel_servo_ctrl;

    localparam int CLOCK_FREQ = 1_000_000;
    localparam int PWM_FREQ   = 200;
    localparam int N          = 4;
    localparam int AW         = 2;
    localparam int P          = 5000;
    localparam int W_0        = 1000;
    localparam int W_128      = 1384;
    localparam int W_192      = 1576;
    localparam int W_255      = 1765;

    typedef struct {
        int at;
        int sel;
        int dat;
    } load_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [7:0]    duty;
    logic [AW-1:0] sel;
    logic [N-1:0]  pwm;
    logic [N-1:0]  prev_pwm;

    int    n_vec = 0;
    int    n_err = 0;
    int    hi_cnt  [N];
    bit    shape_ok[N];
    int    rise_at [N];
    load_t sched[$];

    always #5 clk = ~clk;

    n_channel_servo_ctrl #(
        .CLOCK_FREQ    (CLOCK_FREQ),
        .NO_OF_CHANNEL (N),
        .PWM_FREQ      (PWM_FREQ),
        .MIN_PULSE_US  (1000),
        .MAX_PULSE_US  (2000)
    ) dut (
        .CLOCK              (clk),
        .RESET              (rst),
        .LOAD_SIGNAL        (load),
        .DUTY_CYCLE_CONTROL (duty),
        .SERVO_SELECTOR     (sel),
        .PWM_SIGNALS        (pwm)
    );

    // Samples one frame of outputs on falling edges, aligned to reset release,
    // applying any scheduled loads; index i means the load is seen by the
    // rising edge where the period counter equals i+1.
    task automatic run_frame();
        bit seen_low[N];
        for (int k = 0; k < N; k++) begin
            hi_cnt[k]   = 0;
            shape_ok[k] = 1'b1;
            seen_low[k] = 1'b0;
            rise_at[k]  = -1;
        end
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (pwm[k]) begin
                    hi_cnt[k] = hi_cnt[k] + 1;
                    if (seen_low[k]) shape_ok[k] = 1'b0;
                    if (rise_at[k] < 0 && !prev_pwm[k]) rise_at[k] = i;
                end else begin
                    seen_low[k] = 1'b1;
                end
            end
            prev_pwm = pwm;
            load = 1'b0;
            foreach (sched[j]) begin
                if (sched[j].at == i) begin
                    load = 1'b1;
                    sel  = AW'(sched[j].sel);
                    duty = 8'(sched[j].dat);
                end
            end
        end
        load = 1'b0;
        sched.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b0;
        duty = 8'd0;
        sel  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (pwm !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want 0000", pwm);
        end
        rst      = 1'b0;
        prev_pwm = '0;
    endtask

`ifdef SERVO_PHASE_STAGGER_EN
    task automatic test_stagger();
        int exp_rise;
        run_frame();
        run_frame();
        for (int k = 0; k < N; k++) begin
            exp_rise = (P - k * (P / N)) % P;
            n_vec++;
            if (rise_at[k] !== exp_rise) begin
                n_err++;
                $display("FAIL stagger_rise ch%0d: rose at %0d, want %0d", k, rise_at[k], exp_rise);
            end
        end
    endtask
`else
    task automatic test_default_width();
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== W_128 || !shape_ok[k]) begin
                n_err++;
                $display("FAIL default_width ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], W_128);
            end
        end
    endtask

    task automatic test_load_ch0();
        int exp_a[N] = '{W_128, W_128, W_128, W_128};
        int exp_b[N] = '{W_0, W_128, W_128, W_128};
        sched.push_back('{100, 0, 0});
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_a[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL load_ch0_same_frame ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_a[k]);
            end
        end
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_b[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL load_ch0_next_frame ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_multi_load();
        int exp_a[N] = '{W_0, W_128, W_128, W_128};
        int exp_b[N] = '{W_0, W_128, W_255, W_192};
        sched.push_back('{10, 1, 128});
        sched.push_back('{20, 2, 255});
        sched.push_back('{30, 3, 192});
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_a[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL multi_load_same_frame ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_a[k]);
            end
        end
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_b[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL multi_load_next_frame ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_b[k]);
            end
        end
    endtask

    // Load on the wrap cycle, then a held strobe where the last value must win.
    task automatic test_wrap_load();
        int exp_a[N] = '{W_0, W_128, W_255, W_192};
        int exp_c[N] = '{W_0, W_128, W_0, W_255};
        sched.push_back('{P - 2, 2, 0});
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_a[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL wrap_load_frame ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_a[k]);
            end
        end
        sched.push_back('{200, 3, 10});
        sched.push_back('{201, 3, 255});
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_a[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL wrap_load_old_width ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_a[k]);
            end
        end
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== exp_c[k] || !shape_ok[k]) begin
                n_err++;
                $display("FAIL wrap_load_new_width ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], exp_c[k]);
            end
        end
    endtask

    // Reset mid-pulse with a competing load: reset must win and restore defaults.
    task automatic test_reset_mid();
        repeat (500) @(negedge clk);
        n_vec++;
        if (pwm !== 4'b1111) begin
            n_err++;
            $display("FAIL pre_reset_pulse: got %b, want 1111", pwm);
        end
        rst  = 1'b1;
        load = 1'b1;
        sel  = 2'd0;
        duty = 8'd0;
        @(negedge clk);
        n_vec++;
        if (pwm !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b, want 0000", pwm);
        end
        rst      = 1'b0;
        load     = 1'b0;
        prev_pwm = '0;
        run_frame();
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (hi_cnt[k] !== W_128 || !shape_ok[k]) begin
                n_err++;
                $display("FAIL reset_mid_defaults ch%0d: high=%0d contiguous=%0b, want high=%0d contiguous=1",
                         k, hi_cnt[k], shape_ok[k], W_128);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SERVO_PHASE_STAGGER_EN
        test_stagger();
`else
        test_default_width();
        test_load_ch0();
        test_multi_load();
        test_wrap_load();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
